sdram_client: RTL and testbench
===============================

Name: sdram_client

Overview:
- Initiator side of the memory controller's user interface. Converts a byte-wide host request/acknowledge bus into the controller's word-wide read/write/refresh strobes.
- Observes the controller's busy signal and captures returned read data.
- Owns periodic auto-refresh scheduling.
- Sits between the cartridge/CPU bus logic and memory_controller.

Parameters:
- FREQ, 54_000_000, clk frequency in Hz.
- REFRESH_US, 15, auto-refresh interval in microseconds. Interval in cycles is REFRESH_CYCLES = FREQ/1_000_000*REFRESH_US, which is 810 at the defaults.

Ports:
- clk  in  1  main logic clock, shared with memory_controller.
- resetn  in  1  asynchronous active-low reset.
- host_req  in  1  level request; held until host_ack.
- host_we  in  1  1 = write, 0 = read; sampled with host_req.
- host_addr  in  23  byte address.
- host_wdata  in  8  write byte.
- host_rdata  out  8  read byte; valid from host_ack onward, held until the next read completes.
- host_ack  out  1  one-cycle completion pulse.
- mc_read  out  1  read strobe to the controller.
- mc_write  out  1  write strobe.
- mc_refresh  out  1  refresh strobe.
- mc_addr  out  22  word address, = host_addr[22:1].
- mc_din  out  16  write data, = {host_wdata, host_wdata}.
- mc_wdm  out  2  byte mask, active high = masked. addr[0]=0 gives 2'b10; addr[0]=1 gives 2'b01. Reads and refresh use 2'b00.
- mc_dout  in  16  controller read data.
- mc_busy  in  1  controller busy; high throughout SDRAM initialisation.
- refresh_missed  out  1  sticky debug flag: a refresh tick occurred while a refresh was still pending.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Refresh counter loaded with REFRESH_CYCLES-1.
  - refresh_pending 0.
- All outputs are registered.
- Refresh timer:
  - Free-running down-counter. At 0 it reloads REFRESH_CYCLES-1 and sets refresh_pending.
  - If refresh_pending is already 1 on a tick, set refresh_missed; it is only cleared by reset.
- State machine IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE, mc_busy=0, refresh_pending=1:
    - Refresh has priority over a host request.
    - Set mc_refresh=1, latch op=REFRESH, clear refresh_pending, go to ISSUE.
    - A tick arriving in the same cycle re-sets pending and does not set refresh_missed.
  - IDLE, mc_busy=0, no pending refresh, host_req=1:
    - Latch host_we, host_addr, host_wdata into request registers.
    - Drive mc_read or mc_write plus mc_addr, mc_din and mc_wdm from them.
    - Go to ISSUE.
  - IDLE, mc_busy=1: wait. This covers SDRAM init after reset; no strobe is issued.
  - ISSUE (1 cycle):
    - The controller samples the strobe this cycle.
    - Next cycle all strobes are 0; go to WAIT.
    - mc_addr, mc_din and mc_wdm hold their values until return to IDLE.
  - WAIT: leave when mc_busy=0, which is the first low cycle after busy rose.
    - Read: host_rdata <= addr[0] ? mc_dout[15:8] : mc_dout[7:0].
    - Read or write: pulse host_ack for 1 cycle.
    - Refresh: no ack.
    - Go to IDLE.
- Strobes are never high for more than 1 cycle, and never more than one strobe at a time.
- Latency with an idle controller and no pending refresh:
  - host_req seen in IDLE at cycle 0.
  - Strobe high at cycle 1.
  - mc_busy high cycles 2..5.
  - host_ack at cycle 7.
- host_ack is high only in the IDLE cycle following WAIT. The host must drop host_req that cycle or it is taken as a new request the next IDLE cycle.
- host_req dropped before ack: the latched request still completes and acks.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - The controller may still be busy; IDLE waits for mc_busy=0.

Decomposition:
- Package sdram_client_pkg holds:
  - state enum {IDLE, ISSUE, WAIT};
  - op enum {OP_READ, OP_WRITE, OP_REFRESH};
  - function computing REFRESH_CYCLES from FREQ and REFRESH_US;
  - WDM_LO=2'b10 and WDM_HI=2'b01.
- One sub-module, refresh_timer:
  - inputs: clk, resetn, clear;
  - outputs: pending, missed;
  - parameter: CYCLES.

Test Plan:
- Init hold: reset, mc_busy=1 for 200 cycles, host_req=1 -> no strobe until mc_busy=0, then mc_read 1 cycle later.
- Byte write: addr=23'h000101, wdata=8'hA5, we=1 -> mc_write 1 cycle, mc_addr=22'h000080, mc_din=16'hA5A5, mc_wdm=2'b01, host_ack 1 cycle after busy falls (cycle 7).
- Byte read: controller model returns 16'h3C7E. addr=23'h000010 gives host_rdata=8'h7E; addr=23'h000011 gives 8'h3C. Each has exactly one ack pulse.
- Refresh cadence: idle for 3 intervals at defaults -> mc_refresh pulses at cycles 810, 1620 and 2430 after reset (±controller wait), no host_ack, refresh_missed=0.
- Refresh priority and missed: hold mc_busy=1 across two ticks -> refresh_missed=1. With host_req and refresh pending simultaneously at busy release -> mc_refresh issued first, host access next.
- Reset mid-WAIT: assert resetn=0 during WAIT -> host_ack, strobes and refresh_missed are 0 immediately. After release, waits for mc_busy=0 before the next request.

Source files
------------

// File: rtl/sdram_client_pkg.sv
// Shared types and constants for the SDRAM client.
package sdram_client_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_REFRESH} op_t;

    // Byte masks, active high: low byte written keeps the high byte masked.
    localparam logic [1:0] WDM_LO = 2'b10;
    localparam logic [1:0] WDM_HI = 2'b01;

    // Auto-refresh interval in clock cycles.
    function automatic int refresh_cycles(input int freq, input int us);
        return freq / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/sdram_client_if.sv
// Host-side byte bus and controller-side word bus of the SDRAM client.
interface sdram_client_if;
    logic        host_req;
    logic        host_we;
    logic [22:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        mc_read;
    logic        mc_write;
    logic        mc_refresh;
    logic [21:0] mc_addr;
    logic [15:0] mc_din;
    logic [1:0]  mc_wdm;
    logic [15:0] mc_dout;
    logic        mc_busy;

    // Client (initiator) side.
    modport master (
        input  host_req, host_we, host_addr, host_wdata, mc_dout, mc_busy,
        output host_rdata, host_ack, mc_read, mc_write, mc_refresh,
               mc_addr, mc_din, mc_wdm
    );

    // Host plus controller side, as seen from outside the client.
    modport slave (
        output host_req, host_we, host_addr, host_wdata, mc_dout, mc_busy,
        input  host_rdata, host_ack, mc_read, mc_write, mc_refresh,
               mc_addr, mc_din, mc_wdm
    );
endinterface

// File: rtl/sdram_client_refresh_timer.sv
// Free-running refresh interval timer with a pending flag and a sticky
// overrun flag.
module refresh_timer #(
    parameter int CYCLES = 810
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic pending,
    output logic missed
);
    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] r_cnt;
    logic         r_pending;
    logic         r_missed;
    logic         w_tick;

    assign w_tick  = (r_cnt == '0);
    assign pending = r_pending;
    assign missed  = r_missed;

    // Down-count; a tick beats a same-cycle clear so no interval is lost,
    // and only counts as missed if the old request was not being served.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt     <= RELOAD;
            r_pending <= 1'b0;
            r_missed  <= 1'b0;
        end else begin
            r_cnt <= w_tick ? RELOAD : r_cnt - W'(1);
            if (w_tick) begin
                r_pending <= 1'b1;
                if (r_pending && !clear)
                    r_missed <= 1'b1;
            end else if (clear) begin
                r_pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sdram_client.sv
// SDRAM client: byte host bus to word controller strobes, plus refresh
// scheduling. All outputs come straight from registers.
module sdram_client
    import sdram_client_pkg::*;
#(
    parameter int FREQ       = 54_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic           clk,
    input  logic           resetn,
    sdram_client_if.master bus,
    output logic           refresh_missed
);
    localparam int REFRESH_CYCLES = refresh_cycles(FREQ, REFRESH_US);

    state_t      r_state;
    op_t         r_op;
    logic        r_byte_hi;
    logic [7:0]  r_host_rdata;
    logic        r_host_ack;
    logic        r_mc_read;
    logic        r_mc_write;
    logic        r_mc_refresh;
    logic [21:0] r_mc_addr;
    logic [15:0] r_mc_din;
    logic [1:0]  r_mc_wdm;
    logic        w_pending;
    logic        w_clear;

    // Refresh is accepted exactly when IDLE launches it below.
    assign w_clear = (r_state == IDLE) && !bus.mc_busy && w_pending;

    refresh_timer #(.CYCLES(REFRESH_CYCLES)) u_refresh_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_clear),
        .pending (w_pending),
        .missed  (refresh_missed)
    );

    assign bus.host_rdata = r_host_rdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.mc_read    = r_mc_read;
    assign bus.mc_write   = r_mc_write;
    assign bus.mc_refresh = r_mc_refresh;
    assign bus.mc_addr    = r_mc_addr;
    assign bus.mc_din     = r_mc_din;
    assign bus.mc_wdm     = r_mc_wdm;

    // IDLE -> ISSUE -> WAIT -> IDLE; strobes and ack are single-cycle pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_op         <= OP_READ;
            r_byte_hi    <= 1'b0;
            r_host_rdata <= '0;
            r_host_ack   <= 1'b0;
            r_mc_read    <= 1'b0;
            r_mc_write   <= 1'b0;
            r_mc_refresh <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_din     <= '0;
            r_mc_wdm     <= '0;
        end else begin
            r_host_ack   <= 1'b0;
            r_mc_read    <= 1'b0;
            r_mc_write   <= 1'b0;
            r_mc_refresh <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!bus.mc_busy) begin
                        if (w_pending) begin
                            r_mc_refresh <= 1'b1;
                            r_mc_wdm     <= 2'b00;
                            r_op         <= OP_REFRESH;
                            r_state      <= ISSUE;
                        end else if (bus.host_req) begin
                            r_op       <= bus.host_we ? OP_WRITE : OP_READ;
                            r_mc_read  <= !bus.host_we;
                            r_mc_write <= bus.host_we;
                            r_mc_addr  <= bus.host_addr[22:1];
                            r_mc_din   <= {bus.host_wdata, bus.host_wdata};
                            r_mc_wdm   <= !bus.host_we   ? 2'b00 :
                                          bus.host_addr[0] ? WDM_HI : WDM_LO;
                            r_byte_hi  <= bus.host_addr[0];
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (!bus.mc_busy) begin
                        if (r_op == OP_READ)
                            r_host_rdata <= r_byte_hi ? bus.mc_dout[15:8]
                                                      : bus.mc_dout[7:0];
                        if (r_op != OP_REFRESH)
                            r_host_ack <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_client.sv
// Directed bench for sdram_client with a simple 4-cycle-busy controller model.
module tb_sdram_client;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic refresh_missed;
    logic init_busy = 1'b1;
    logic [2:0] bcnt = '0;
    int n_checks = 0;
    int n_err = 0;

    sdram_client_if bus();

    sdram_client #(.FREQ(54_000_000), .REFRESH_US(15)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .refresh_missed (refresh_missed)
    );

    always #5 clk = ~clk;

    // Controller model: busy for the 4 cycles after a strobe, plus forced busy.
    assign bus.mc_busy = init_busy | (bcnt != 3'd0);
    assign bus.mc_dout = 16'h3C7E;
    always @(posedge clk) begin
        if (bus.mc_read | bus.mc_write | bus.mc_refresh) bcnt <= 3'd4;
        else if (bcnt != 3'd0) bcnt <= bcnt - 3'd1;
    end

    typedef struct {
        logic        we;
        logic [22:0] addr;
        logic [7:0]  wdata;
        logic [21:0] exp_addr;
        logic [15:0] exp_din;
        logic [1:0]  exp_wdm;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int k);
        case (k)
            0: return bus.mc_read | bus.mc_write;
            1: return bus.host_ack;
            default: return bus.mc_refresh;
        endcase
    endfunction

    task automatic wait_for(input int k, input int bound, input string nm, output int n);
        n = 0;
        while (!sig(k) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!sig(k)) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles", nm, bound);
            n = -1;
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {11'd0, bus.host_ack, bus.mc_read, bus.mc_write, bus.mc_refresh,
                refresh_missed, bus.mc_wdm, bus.host_rdata, bus.mc_addr, bus.mc_din};
    endfunction

    function automatic logic [2:0] strobes();
        return {bus.mc_read, bus.mc_write, bus.mc_refresh};
    endfunction

    task automatic do_reset(input logic busy);
        resetn = 1'b0;
        init_busy = busy;
        bus.host_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, lat, seen, n_ref, n_ack;
        int t_ref[3];

        vecs[0] = '{1'b1, 23'h000101, 8'hA5, 22'h000080, 16'hA5A5, 2'b01, 8'h00};
        vecs[1] = '{1'b0, 23'h000010, 8'h00, 22'h000008, 16'h0000, 2'b00, 8'h7E};
        vecs[2] = '{1'b1, 23'h000100, 8'h5A, 22'h000080, 16'h5A5A, 2'b10, 8'h7E};
        vecs[3] = '{1'b0, 23'h000011, 8'h00, 22'h000008, 16'h0000, 2'b00, 8'h3C};
        vecs[4] = '{1'b1, 23'h7FFFFF, 8'hFF, 22'h3FFFFF, 16'hFFFF, 2'b01, 8'h3C};
        vecs[5] = '{1'b0, 23'h7FFFFE, 8'h00, 22'h3FFFFF, 16'h0000, 2'b00, 8'h7E};

        bus.host_req = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_wdata = '0;

        // Reset values
        @(negedge clk);
        chk("reset_outputs", all_outs(), 64'd0);

        // Init hold: no strobe while the controller is busy
        do_reset(1'b1);
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 23'h000010;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (strobes() != 3'b000) seen++;
        end
        chk("init_no_strobe", seen, 0);
        init_busy = 1'b0;
        @(negedge clk);
        chk("init_read_after_busy", strobes(), 3'b100);
        wait_for(1, 20, "init_ack", n);
        bus.host_req = 1'b0;
        chk("init_rdata", bus.host_rdata, 8'h7E);

        // Table of single accesses
        do_reset(1'b0);
        foreach (vecs[i]) begin
            bus.host_req = 1'b1;
            bus.host_we = vecs[i].we;
            bus.host_addr = vecs[i].addr;
            bus.host_wdata = vecs[i].wdata;
            @(negedge clk);
            chk($sformatf("v%0d_strobe", i), strobes(), vecs[i].we ? 3'b010 : 3'b100);
            chk($sformatf("v%0d_addr", i), bus.mc_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_wdm", i), bus.mc_wdm, vecs[i].exp_wdm);
            if (vecs[i].we) chk($sformatf("v%0d_din", i), bus.mc_din, vecs[i].exp_din);
            @(negedge clk);
            chk($sformatf("v%0d_strobe_1cyc", i), strobes(), 3'b000);
            lat = 1;
            while (!bus.host_ack && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("v%0d_ack_latency", i), lat, 6);
            bus.host_req = 1'b0;
            chk($sformatf("v%0d_rdata", i), bus.host_rdata, vecs[i].exp_rdata);
            @(negedge clk);
            chk($sformatf("v%0d_ack_1cyc", i), {bus.host_ack, strobes()}, 4'b0000);
        end

        // Request dropped before ack still completes
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 23'h000011;
        @(negedge clk);
        chk("drop_read_strobe", strobes(), 3'b100);
        bus.host_req = 1'b0;
        wait_for(1, 20, "drop_ack", n);
        chk("drop_rdata", bus.host_rdata, 8'h3C);

        // Refresh cadence with an idle host
        do_reset(1'b0);
        n_ref = 0;
        n_ack = 0;
        for (int t = 1; t <= 2440; t++) begin
            @(negedge clk);
            if (bus.mc_refresh) begin
                if (n_ref < 3) t_ref[n_ref] = t;
                n_ref++;
            end
            if (bus.host_ack) n_ack++;
        end
        chk("refresh_count", n_ref, 3);
        for (int i = 0; i < 3 && i < n_ref; i++)
            chk($sformatf("refresh_time%0d_at_%0d", i, t_ref[i]),
                (t_ref[i] >= 810 * (i + 1) - 4) && (t_ref[i] <= 810 * (i + 1) + 4), 1'b1);
        chk("refresh_no_ack", n_ack, 0);
        chk("refresh_missed_clear", refresh_missed, 1'b0);

        // Two ticks under busy: missed flag, then refresh before host access
        do_reset(1'b1);
        bus.host_req = 1'b1;
        bus.host_we = 1'b0;
        bus.host_addr = 23'h000011;
        seen = 0;
        repeat (900) begin
            @(negedge clk);
            if (strobes() != 3'b000) seen++;
        end
        chk("missed_after_one_tick", refresh_missed, 1'b0);
        repeat (800) begin
            @(negedge clk);
            if (strobes() != 3'b000) seen++;
        end
        chk("missed_after_two_ticks", refresh_missed, 1'b1);
        chk("busy_hold_no_strobe", seen, 0);
        init_busy = 1'b0;
        @(negedge clk);
        chk("priority_refresh_first", strobes(), 3'b001);
        @(negedge clk);
        wait_for(0, 20, "priority_host_next", n);
        chk("priority_read_strobe", strobes(), 3'b100);
        wait_for(1, 20, "priority_ack", n);
        bus.host_req = 1'b0;
        chk("priority_rdata", bus.host_rdata, 8'h3C);
        @(negedge clk);

        // Reset in the middle of WAIT
        bus.host_req = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = 23'h000101;
        bus.host_wdata = 8'hA5;
        @(negedge clk);
        chk("midwait_write_strobe", strobes(), 3'b010);
        @(negedge clk);
        @(negedge clk);
        chk("midwait_missed_before", refresh_missed, 1'b1);
        resetn = 1'b0;
        init_busy = 1'b1;
        #1;
        chk("midwait_reset_outputs", all_outs(), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (strobes() != 3'b000) seen++;
        end
        chk("midwait_hold_no_strobe", seen, 0);
        init_busy = 1'b0;
        @(negedge clk);
        chk("midwait_write_after_busy", strobes(), 3'b010);
        wait_for(1, 20, "midwait_ack", n);
        bus.host_req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
